// File: rtl/tt_dma_pkg.sv
// Shared types and constants for the tt_dma byte-copy engine.
package tt_dma_pkg;

  localparam int DEPTH     = 8;
  localparam int BURST_LEN = 4;
  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 8;
  localparam int CNT_W     = $clog2(BURST_LEN);

  // Memory content after reset, entry 0 is the leftmost character.
  localparam logic [DEPTH*DATA_W-1:0] RESET_TEXT = "ABCDEFGH";

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  function automatic logic [DATA_W-1:0] reset_byte(input int idx);
    return RESET_TEXT[(DEPTH-1-idx)*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/tt_dma_core.sv
// DMA core: command latch, read/write FSM, burst counter and the private memory.
module dma_core
  import tt_dma_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic              mode,
  output logic              done,
  output logic [6:0]        data_out
);

  state_t              state;
  state_t              next_state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_buf;
  logic [CNT_W-1:0]    counter;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic                mode_q;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   wr_addr;
  logic                last_word;

  // Addresses wrap modulo DEPTH simply by truncating to ADDR_W bits.
  assign rd_addr   = src_q + ADDR_W'(counter);
  assign wr_addr   = dst_q + ADDR_W'(counter);
  assign last_word = !mode_q || (counter == CNT_W'(BURST_LEN - 1));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    // NOTE: default assigned first so no path leaves next_state unassigned (no latch).
    next_state = state;
    case (state)
      IDLE:    if (ena && start) next_state = READ;
      READ:    next_state = WRITE;
      WRITE:   next_state = last_word ? DONE : READ;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: command latch, memory copy, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the memory is reset on purpose; reset restores the "ABCDEFGH" image.
      for (int i = 0; i < DEPTH; i++) mem[i] <= reset_byte(i);
      rd_buf   <= '0;
      counter  <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      mode_q   <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (ena && start) begin
            src_q   <= src;
            dst_q   <= dst;
            mode_q  <= mode;
            counter <= '0;
          end
        end
        READ:  rd_buf <= mem[rd_addr];
        WRITE: begin
          mem[wr_addr] <= rd_buf;
          data_out     <= rd_buf[6:0];
          if (!last_word) counter <= counter + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tt_dma_top.sv
// Tiny Tapeout wrapper: maps pad-ring pins onto dma_core and ties off the uio bus.
module tt_dma_top
  import tt_dma_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic       done;
  logic [6:0] data_out;
  logic       unused_uio;

  assign unused_uio = ^uio_in;

  dma_core dma_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .start    (ui_in[7]),
    .src      (ui_in[6:4]),
    .dst      (ui_in[3:1]),
    .mode     (ui_in[0]),
    .done     (done),
    .data_out (data_out)
  );

  assign uo_out  = {done, data_out};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_dma_top.sv
// Self-checking bench for tt_dma_top against a byte-array model of the copy engine.
module tb_tt_dma_top;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] model_mem [8];
  logic [6:0] model_data;

  tt_dma_top dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_mem[i] = 8'h41 + 8'(i);
    model_data = 7'h00;
  endtask

  // Ascending copy, one word at a time, addresses modulo 8.
  task automatic model_copy(input int s, input int d, input int m);
    int n;
    n = m ? 4 : 1;
    for (int k = 0; k < n; k++) begin
      model_mem[(d + k) % 8] = model_mem[(s + k) % 8];
      model_data = model_mem[(d + k) % 8][6:0];
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_data"}, int'(uo_out[6:0]), int'(model_data));
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_mem%0d", tag, i), int'(dut.dma_core.mem[i]), int'(model_mem[i]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ui_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Issue one command. Start is held for 'hold' edges (1 = single pulse),
  // ena is applied on the acceptance edge and optionally dropped afterwards.
  task automatic run_cmd(input string tag, input int s, input int d, input int m,
                         input int hold, input logic ena_v, input logic ena_drop);
    int n, exp_edge, first, dones;
    n = m ? 4 : 1;
    exp_edge = 2 * n + 2;
    first = -1;
    dones = 0;
    @(negedge clk);
    ena   = ena_v;
    ui_in = {1'b1, 3'(s), 3'(d), 1'(m)};
    for (int k = 1; k <= 2 * n + 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (uo_out[7]) begin
        dones++;
        if (first < 0) first = k;
      end
      if (k == hold) ui_in = 8'h00;
      if (k == 1 && ena_drop) ena = 1'b0;
    end
    ui_in = 8'h00;
    ena   = 1'b1;
    if (ena_v) begin
      model_copy(s, d, m);
      check({tag, "_done_edge"}, first, exp_edge);
      check({tag, "_done_count"}, dones, 1);
    end else begin
      check({tag, "_no_done"}, dones, 0);
    end
    check_state(tag);
  endtask

  initial begin
    int s, d, m, hold;
    logic ev, ed;
    int idle_dones;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state and quiet idle.
    check("rst_uo", int'(uo_out), 0);
    check("rst_uio_out", int'(uio_out), 0);
    check("rst_uio_oe", int'(uio_oe), 0);
    check_state("rst");
    idle_dones = 0;
    uio_in = 8'hA5;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (uo_out[7]) idle_dones++;
    end
    uio_in = 8'h00;
    check("idle_done", idle_dones, 0);

    // Directed: single copy 0->4, then burst 0->4.
    run_cmd("single", 0, 4, 0, 1, 1'b1, 1'b0);
    check("single_byte", int'(dut.dma_core.mem[4]), 8'h41);
    run_cmd("burst", 0, 4, 1, 1, 1'b1, 1'b0);
    check("burst_data", int'(uo_out[6:0]), 7'h44);

    // Wrap burst from reset.
    do_reset();
    run_cmd("wrap", 6, 2, 1, 1, 1'b1, 1'b0);
    check("wrap_m2", int'(dut.dma_core.mem[2]), 8'h47);
    check("wrap_m5", int'(dut.dma_core.mem[5]), 8'h42);

    // Propagating overlap, held start, ena low, ena dropped mid-burst, src==dst.
    run_cmd("prop", 0, 1, 1, 1, 1'b1, 1'b0);
    run_cmd("held", 3, 5, 1, 10, 1'b1, 1'b0);
    run_cmd("held_single", 2, 7, 0, 4, 1'b1, 1'b0);
    run_cmd("ena_low", 1, 6, 1, 3, 1'b0, 1'b0);
    run_cmd("ena_drop", 4, 0, 1, 1, 1'b1, 1'b1);
    run_cmd("same", 5, 5, 1, 1, 1'b1, 1'b0);

    // Reset mid-burst after two words.
    do_reset();
    @(negedge clk);
    ui_in = 8'b1_001_110_1;
    repeat (5) @(negedge clk);
    ui_in = 8'h00;
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    check("midrst_uo", int'(uo_out), 0);
    check_state("midrst");
    rst_n = 1'b1;
    run_cmd("after_rst", 7, 3, 0, 1, 1'b1, 1'b0);

    // Randomized commands.
    for (int t = 0; t < 30; t++) begin
      s    = int'($urandom_range(0, 7));
      d    = int'($urandom_range(0, 7));
      m    = int'($urandom_range(0, 1));
      hold = int'($urandom_range(1, m ? 10 : 4));
      ev   = ($urandom_range(0, 5) != 0);
      ed   = ($urandom_range(0, 3) == 0);
      run_cmd($sformatf("rnd%0d", t), s, d, m, hold, ev, ed);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end

endmodule
